// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed 7-segment scanner: special digit codes,
// the gfedcba pattern table, the scan state encoding and the snapshot reset value.
package seg_pkg;

  localparam logic [3:0] SEG_BLANK = 4'd10;
  localparam logic [3:0] SEG_DASH  = 4'd11;
  localparam logic [3:0] SEG_C     = 4'd12;
  localparam logic [3:0] SEG_E     = 4'd13;
  localparam logic [3:0] SEG_H     = 4'd14;
  localparam logic [3:0] SEG_U     = 4'd15;

  // Active-high gfedcba patterns, indexed by digit code.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h00, 7'h40, 7'h39, 7'h79, 7'h76, 7'h3E
  };

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    SHOW
  } state_e;

  localparam logic [31:0] SNAP_RST = {SEG_U, {7{SEG_BLANK}}};

endpackage

// File: rtl/seg_decode.sv
// Combinational digit-code to active-high gfedcba segment lookup.
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_TABLE[code_i];

endmodule

// File: rtl/seg_scan.sv
// Eight-digit multiplexed 7-segment driver: snapshots dsp_data once per frame and
// scans one digit per dwell, with a leading blank gap to suppress ghosting.
module seg_scan
  import seg_pkg::*;
#(
  parameter logic [27:0] SYS_CLK     = 28'd50_000_000,
  parameter logic [27:0] DIGIT_HZ    = 28'd8_000,
  parameter int          BLANK_CYC   = 16,
  parameter bit          SEG_ACT_LOW = 1'b1,
  parameter bit          SEL_ACT_LOW = 1'b1
) (
  input  logic        seg_clk,
  input  logic        seg_rst,
  input  logic        dsp_en,
  input  logic [31:0] dsp_data,
  input  logic [7:0]  dsp_dp,
  output logic [7:0]  seg_sel,
  output logic [7:0]  seg_led,
  output logic        frame_done
);

  localparam int              DWELL     = int'(SYS_CLK / DIGIT_HZ);
  localparam int              CNT_W     = $clog2(DWELL);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] DWELL_END = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [7:0]      SEG_OFF   = SEG_ACT_LOW ? 8'hFF : 8'h00;
  localparam logic [7:0]      SEL_OFF   = SEL_ACT_LOW ? 8'hFF : 8'h00;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [31:0]      snap_data_q, snap_data_d;
  logic [7:0]       snap_dp_q, snap_dp_d;
  logic [7:0]       seg_sel_q, seg_sel_d;
  logic [7:0]       seg_led_q, seg_led_d;
  logic             frame_done_q, frame_done_d;

  logic             wrap;
  logic             show;
  logic [3:0]       nibble;
  logic [6:0]       seg_pat;
  logic [7:0]       sel_raw;
  logic [7:0]       led_raw;

  assign wrap = (state_q == SHOW) && (cnt_q == DWELL_END) && (idx_q == 3'd7);

  // NOTE: every signal gets a default at the top of the block so no path leaves
  // it unassigned; a missing default here would infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    snap_data_d = snap_data_q;
    snap_dp_d   = snap_dp_q;

    case (state_q)
      IDLE: begin
        if (dsp_en) begin
          state_d     = BLANK;
          cnt_d       = '0;
          idx_d       = '0;
          snap_data_d = dsp_data;
          snap_dp_d   = dsp_dp;
        end
      end
      BLANK: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == BLANK_END) begin
          state_d = SHOW;
        end
      end
      SHOW: begin
        if (cnt_q == DWELL_END) begin
          cnt_d   = '0;
          state_d = BLANK;
          if (idx_q == 3'd7) begin
            idx_d       = '0;
            snap_data_d = dsp_data;
            snap_dp_d   = dsp_dp;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Disable overrides scanning, but a coincident frame wrap still reloads the
    // snapshot and still reports frame_done.
    if (!dsp_en) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end
  end

  assign nibble = snap_data_q[{idx_q, 2'b00} +: 4];

  seg_decode u_decode (
    .code_i (nibble),
    .seg_o  (seg_pat)
  );

  assign show         = (state_q == SHOW);
  assign sel_raw      = show ? (8'b0000_0001 << idx_q) : 8'h00;
  assign led_raw      = show ? {snap_dp_q[idx_q], seg_pat} : 8'h00;
  assign seg_sel_d    = sel_raw ^ SEL_OFF;
  assign seg_led_d    = led_raw ^ SEG_OFF;
  assign frame_done_d = wrap;

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order. The snapshot is a
  // plain register and takes a defined reset value like the rest of the state.
  always_ff @(posedge seg_clk) begin
    if (seg_rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      snap_data_q  <= SNAP_RST;
      snap_dp_q    <= 8'h00;
      seg_sel_q    <= SEL_OFF;
      seg_led_q    <= SEG_OFF;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      snap_data_q  <= snap_data_d;
      snap_dp_q    <= snap_dp_d;
      seg_sel_q    <= seg_sel_d;
      seg_led_q    <= seg_led_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg_sel    = seg_sel_q;
  assign seg_led    = seg_led_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan with DWELL=10, BLANK_CYC=2, active-low pins;
// expected segment bytes are hand-decoded constants.
module tb_seg_scan;
  import seg_pkg::*;

  logic        seg_clk = 1'b0;
  logic        seg_rst;
  logic        dsp_en;
  logic [31:0] dsp_data;
  logic [7:0]  dsp_dp;
  logic [7:0]  seg_sel;
  logic [7:0]  seg_led;
  logic        frame_done;

  int n_checks = 0;
  int n_pass   = 0;

  // Per-digit seg_led bytes {d7..d0}, active-low with dp.
  localparam logic [63:0] EXP_A  = {8'hC1, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hF9, 8'hA4, 8'hB0};
  localparam logic [63:0] EXP_B  = {8'hC1, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hC0, 8'h90};
  localparam logic [63:0] EXP_DP = {8'hC1, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h79, 8'hA4, 8'hB0};

  seg_scan #(
    .SYS_CLK     (28'd1000),
    .DIGIT_HZ    (28'd100),
    .BLANK_CYC   (2),
    .SEG_ACT_LOW (1'b1),
    .SEL_ACT_LOW (1'b1)
  ) dut (
    .seg_clk    (seg_clk),
    .seg_rst    (seg_rst),
    .dsp_en     (dsp_en),
    .dsp_data   (dsp_data),
    .dsp_dp     (dsp_dp),
    .seg_sel    (seg_sel),
    .seg_led    (seg_led),
    .frame_done (frame_done)
  );

  always #5 seg_clk = ~seg_clk;

  // Walks digits 0..stop_digit-1 of a frame: 2 blank cycles then 8 lit cycles each.
  // Optionally changes the input word at the first lit cycle of chg_digit.
  task automatic run_frame(input logic [63:0] exp_led, input int stop_digit,
                           input int chg_digit, input logic [31:0] chg_data,
                           input logic [7:0] chg_dp, input string tag);
    logic [7:0] exp_sel;
    logic [7:0] bad_sel;
    logic [7:0] bad_led;
    logic       blank_ok;
    logic       show_ok;
    logic       fd_ok;
    logic       exp_fd;
    logic       bad_fd;
    fd_ok  = 1'b1;
    bad_fd = 1'b0;
    for (int d = 0; d < stop_digit; d++) begin
      exp_sel  = ~(8'h01 << d);
      blank_ok = 1'b1;
      bad_sel  = 8'h00;
      bad_led  = 8'h00;
      for (int b = 0; b < 2; b++) begin
        @(negedge seg_clk);
        if (blank_ok && (seg_sel !== 8'hFF || seg_led !== 8'hFF)) begin
          blank_ok = 1'b0;
          bad_sel  = seg_sel;
          bad_led  = seg_led;
        end
        if (fd_ok && frame_done !== 1'b0) begin
          fd_ok  = 1'b0;
          bad_fd = frame_done;
        end
      end
      n_checks++;
      if (!blank_ok)
        $display("FAIL %s blank before digit %0d: sel=%h led=%h, expected sel=ff led=ff",
                 tag, d, bad_sel, bad_led);
      else
        n_pass++;

      show_ok = 1'b1;
      for (int j = 0; j < 8; j++) begin
        @(negedge seg_clk);
        exp_fd = (d == 7 && j == 7);
        if (show_ok && (seg_sel !== exp_sel || seg_led !== exp_led[d*8 +: 8])) begin
          show_ok = 1'b0;
          bad_sel = seg_sel;
          bad_led = seg_led;
        end
        if (fd_ok && frame_done !== exp_fd) begin
          fd_ok  = 1'b0;
          bad_fd = frame_done;
        end
        if (d == chg_digit && j == 0) begin
          dsp_data = chg_data;
          dsp_dp   = chg_dp;
        end
      end
      n_checks++;
      if (!show_ok)
        $display("FAIL %s digit %0d lit: sel=%h led=%h, expected sel=%h led=%h",
                 tag, d, bad_sel, bad_led, exp_sel, exp_led[d*8 +: 8]);
      else
        n_pass++;
    end
    n_checks++;
    if (!fd_ok)
      $display("FAIL %s frame_done timing: saw %b at a cycle where it should not be",
               tag, bad_fd);
    else
      n_pass++;
  endtask

  task automatic test_reset();
    seg_rst  = 1'b1;
    dsp_en   = 1'b0;
    dsp_data = 32'hFAAAA123;
    dsp_dp   = 8'h00;
    repeat (3) @(negedge seg_clk);
    n_checks++;
    if (seg_sel !== 8'hFF) $display("FAIL reset seg_sel: got %h, expected ff", seg_sel);
    else n_pass++;
    n_checks++;
    if (seg_led !== 8'hFF) $display("FAIL reset seg_led: got %h, expected ff", seg_led);
    else n_pass++;
    n_checks++;
    if (frame_done !== 1'b0) $display("FAIL reset frame_done: got %b, expected 0", frame_done);
    else n_pass++;
    n_checks++;
    if (dut.state_q !== IDLE || dut.idx_q !== 3'd0 || dut.cnt_q !== '0)
      $display("FAIL reset state: state=%0d idx=%0d cnt=%0d, expected 0/0/0",
               dut.state_q, dut.idx_q, dut.cnt_q);
    else n_pass++;
    seg_rst = 1'b0;
    @(negedge seg_clk);
  endtask

  // Enable rises: one idle-output cycle, then the normal blank/lit rhythm.
  task automatic test_first_frame();
    dsp_en = 1'b1;
    @(negedge seg_clk);
    n_checks++;
    if (seg_sel !== 8'hFF) $display("FAIL start latency: sel=%h one cycle after enable, expected ff", seg_sel);
    else n_pass++;
    run_frame(EXP_A, 8, -1, 32'h0, 8'h00, "first_frame");
  endtask

  task automatic test_no_tearing();
    run_frame(EXP_A, 8, 3, 32'hFAAAAA09, 8'h00, "tear_hold");
    run_frame(EXP_B, 8, 0, 32'hFAAAA123, 8'h04, "tear_next");
  endtask

  task automatic test_dp();
    run_frame(EXP_DP, 8, -1, 32'h0, 8'h00, "dp_digit2");
  endtask

  task automatic test_drop_enable();
    logic dark_ok;
    logic [7:0] bad_sel;
    logic [7:0] bad_led;
    logic bad_fd;
    run_frame(EXP_DP, 5, -1, 32'h0, 8'h00, "pre_drop");
    repeat (3) @(negedge seg_clk);
    dsp_en = 1'b0;
    @(negedge seg_clk);
    dark_ok = 1'b1;
    bad_sel = 8'h00;
    bad_led = 8'h00;
    bad_fd  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge seg_clk);
      if (dark_ok && (seg_sel !== 8'hFF || seg_led !== 8'hFF || frame_done !== 1'b0)) begin
        dark_ok = 1'b0;
        bad_sel = seg_sel;
        bad_led = seg_led;
        bad_fd  = frame_done;
      end
    end
    n_checks++;
    if (!dark_ok)
      $display("FAIL drop_enable dark: sel=%h led=%h fd=%b, expected ff ff 0",
               bad_sel, bad_led, bad_fd);
    else n_pass++;
    n_checks++;
    if (dut.state_q !== IDLE || dut.idx_q !== 3'd0)
      $display("FAIL drop_enable state: state=%0d idx=%0d, expected 0/0", dut.state_q, dut.idx_q);
    else n_pass++;
    dsp_dp = 8'h00;
    dsp_en = 1'b1;
    @(negedge seg_clk);
    run_frame(EXP_A, 8, -1, 32'h0, 8'h00, "restart");
  endtask

  // Reset lands on the cycle that would otherwise produce frame_done.
  task automatic test_reset_mid_show();
    run_frame(EXP_A, 7, -1, 32'h0, 8'h00, "pre_rst");
    repeat (9) @(negedge seg_clk);
    seg_rst = 1'b1;
    @(negedge seg_clk);
    n_checks++;
    if (seg_sel !== 8'hFF || seg_led !== 8'hFF)
      $display("FAIL rst_mid_show outputs: sel=%h led=%h, expected ff ff", seg_sel, seg_led);
    else n_pass++;
    n_checks++;
    if (frame_done !== 1'b0) $display("FAIL rst_mid_show frame_done: got %b, expected 0", frame_done);
    else n_pass++;
    n_checks++;
    if (dut.state_q !== IDLE) $display("FAIL rst_mid_show state: got %0d, expected 0", dut.state_q);
    else n_pass++;
    seg_rst = 1'b0;
  endtask

  task automatic test_free_run();
    int  last_pulse;
    int  n_pulses;
    logic onehot_ok;
    logic [7:0] bad_sel;
    last_pulse = -1;
    n_pulses   = 0;
    onehot_ok  = 1'b1;
    bad_sel    = 8'h00;
    dsp_en     = 1'b1;
    for (int cyc = 0; cyc < 330; cyc++) begin
      @(negedge seg_clk);
      if (onehot_ok && $countones(~seg_sel) > 1) begin
        onehot_ok = 1'b0;
        bad_sel   = seg_sel;
      end
      if (frame_done === 1'b1) begin
        if (last_pulse >= 0) begin
          n_checks++;
          if (cyc - last_pulse !== 80)
            $display("FAIL free_run period: got %0d cycles, expected 80", cyc - last_pulse);
          else n_pass++;
        end
        last_pulse = cyc;
        n_pulses++;
      end
    end
    n_checks++;
    if (n_pulses < 3) $display("FAIL free_run pulse count: got %0d, expected at least 3", n_pulses);
    else n_pass++;
    n_checks++;
    if (!onehot_ok) $display("FAIL free_run select: sel=%h, expected at most one low bit", bad_sel);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_no_tearing();
    test_dp();
    test_drop_enable();
    test_reset_mid_show();
    test_free_run();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
